ram_fifo_ctrl: RTL

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

---
 rtl/ram_fifo_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/ram_fifo_ctrl.sv
// ram_fifo_ctrl: FIFO controller driving an external dual-port RAM.
// Port A writes, port B reads with a registered one-cycle latency.
module ram_fifo_ctrl #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int AFULL_TH = 240
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   count,
  output logic              ovf,
  output logic              udf,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [DATA_W-1:0] ram_data_in_a,
  output logic              ram_we_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic              ram_we_b,
  input  logic [DATA_W-1:0] ram_data_out_b
);

  localparam logic [ADDR_W:0] DEPTH_C =
    {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AFULL_C =
    (ADDR_W+1)'(AFULL_TH);

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              pop_valid_q, pop_valid_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              push_acc, pop_acc;

  // Status flags come straight from the registered occupancy.
  always_comb begin
    empty       = (count_q == '0);
    full        = (count_q == DEPTH_C);
    almost_full = (count_q >= AFULL_C);
  end

  // Accept logic, next-state and RAM port drive.
  // The write strobe is held off while reset is asserted.
  always_comb begin
    push_acc    = push & ~full & rst_n;
    pop_acc     = pop & ~empty;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    pop_valid_d = pop_acc;
    ovf_d       = ovf_q | (push & full);
    udf_d       = udf_q | (pop & empty);
    if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_acc)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      pop_valid_q <= 1'b0;
      ovf_q       <= 1'b0;
      udf_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      pop_valid_q <= pop_valid_d;
      ovf_q       <= ovf_d;
      udf_q       <= udf_d;
    end
  end

  // Output wiring; RAM read data is passed through unregistered.
  always_comb begin
    ram_addr_a    = wr_ptr_q;
    ram_data_in_a = push_data;
    ram_we_a      = push_acc;
    ram_addr_b    = rd_ptr_q;
    ram_we_b      = 1'b0;
    pop_data      = ram_data_out_b;
    pop_valid     = pop_valid_q;
    count         = count_q;
    ovf           = ovf_q;
    udf           = udf_q;
  end

endmodule
